// File: rtl/matvec_pkg.sv
// Shared types and constants for the matvec job arbiter.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int MV_WIDTH     = 14;
    localparam int MV_OUT_WIDTH = 28;
    localparam int MV_MAT_DIM   = 3;

    // Words in one job: full matrix plus vector, or vector only.
    function automatic int job_len(input logic nm, input int dim);
        if (nm) begin
            return dim * dim + dim;
        end else begin
            return dim;
        end
    endfunction

endpackage

// File: rtl/matvec_job_arbiter_rr_pick.sv
// Combinational round-robin search: lowest requester at or above the pointer wins, with wrap.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic             o_any
);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;

    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[N_REQ-1:0];
    assign o_any = |i_req;

    // Scan downward so the lowest rotated position is the last (winning) assignment.
    always_comb begin
        o_winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_winner = '0;
                o_winner[PW'((k + int'(i_ptr)) % N_REQ)] = 1'b1;
            end else begin
                o_winner = o_winner;
            end
        end
    end

endmodule

// File: rtl/matvec_job_arbiter.sv
// Round-robin job arbiter sharing one matvec engine among N_REQ requesters.
// Optional stale-matrix detection is enabled by defining MATVEC_ARB_OWNER_CHECK_EN.
module matvec_job_arbiter
    import matvec_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int WIDTH     = MV_WIDTH,
    parameter int OUT_WIDTH = MV_OUT_WIDTH,
    parameter int MAT_DIM   = MV_MAT_DIM
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_new_matrix,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [OUT_WIDTH-1:0]   rsp_data,
    output logic                   mv_input_valid,
    input  logic                   mv_input_ready,
    output logic [WIDTH-1:0]       mv_input_data,
    output logic                   mv_new_matrix,
    input  logic                   mv_output_valid,
    output logic                   mv_output_ready,
    input  logic [OUT_WIDTH-1:0]   mv_output_data,
    output logic [N_REQ-1:0]       grant,
`ifdef MATVEC_ARB_OWNER_CHECK_EN
    output logic                   err_stale_matrix,
`endif
    output logic                   busy
);

    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WCW = $clog2(MAT_DIM * MAT_DIM + MAT_DIM + 1);
    localparam int RCW = $clog2(MAT_DIM + 1);

    arb_state_t       r_state, w_next_state;
    logic [N_REQ-1:0] r_grant, w_winner;
    logic [PW-1:0]    r_ptr, r_gidx, w_win_idx;
    logic             r_job_nm, w_any, w_win_nm;
    logic [WCW-1:0]   r_job_len, r_word_cnt;
    logic [RCW-1:0]   r_rsp_cnt;
    logic             w_in_hs, w_out_hs, w_last_word, w_last_rsp;
    logic [WIDTH-1:0] w_in_data;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_rr_pick (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Winner index/flag and granted load word, by one-hot OR-reduction.
    always_comb begin
        w_win_idx = '0;
        w_in_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_win_idx = w_win_idx | (w_winner[k] ? PW'(k) : '0);
            w_in_data = w_in_data | (r_grant[k] ? req_data[k*WIDTH +: WIDTH] : '0);
        end
    end

    assign w_win_nm    = |(w_winner & req_new_matrix);
    assign w_in_hs     = mv_input_valid && mv_input_ready;
    assign w_out_hs    = mv_output_valid && mv_output_ready;
    assign w_last_word = (r_word_cnt == r_job_len - WCW'(1));
    assign w_last_rsp  = (r_rsp_cnt == RCW'(MAT_DIM - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = LOAD; else w_next_state = IDLE;
            LOAD:    if (w_in_hs && w_last_word) w_next_state = DRAIN; else w_next_state = LOAD;
            DRAIN:   if (w_out_hs && w_last_rsp) w_next_state = IDLE; else w_next_state = DRAIN;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: zero-latency routing between the owner and the engine.
    always_comb begin
        req_ready       = '0;
        rsp_valid       = '0;
        mv_input_valid  = 1'b0;
        mv_input_data   = '0;
        mv_output_ready = 1'b0;
        case (r_state)
            LOAD: begin
                mv_input_valid = |(req_valid & r_grant);
                mv_input_data  = w_in_data;
                req_ready      = r_grant & {N_REQ{mv_input_ready}};
            end
            DRAIN: begin
                rsp_valid       = r_grant & {N_REQ{mv_output_valid}};
                mv_output_ready = |(rsp_ready & r_grant);
            end
            default: begin
                mv_input_valid = 1'b0;
            end
        endcase
    end

    assign rsp_data      = mv_output_data;
    assign grant         = r_grant;
    assign busy          = (r_state != IDLE);
    assign mv_new_matrix = busy & r_job_nm;

    // Job bookkeeping: capture owner at grant, count words and results, advance pointer on release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_job_nm   <= 1'b0;
            r_job_len  <= '0;
            r_word_cnt <= '0;
            r_rsp_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_winner;
                        r_gidx    <= w_win_idx;
                        r_job_nm  <= w_win_nm;
                        r_job_len <= WCW'(job_len(w_win_nm, MAT_DIM));
                    end else begin
                        r_grant <= '0;
                    end
                end
                LOAD: begin
                    if (w_in_hs) begin
                        r_word_cnt <= w_last_word ? '0 : r_word_cnt + WCW'(1);
                    end else begin
                        r_word_cnt <= r_word_cnt;
                    end
                end
                DRAIN: begin
                    if (w_out_hs && w_last_rsp) begin
                        r_rsp_cnt <= '0;
                        r_grant   <= '0;
                        r_ptr     <= (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);
                    end else if (w_out_hs) begin
                        r_rsp_cnt <= r_rsp_cnt + RCW'(1);
                    end else begin
                        r_rsp_cnt <= r_rsp_cnt;
                    end
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef MATVEC_ARB_OWNER_CHECK_EN
    logic [PW-1:0] r_owner;
    logic          r_owner_vld;
    logic          r_err_stale;

    // Track who loaded the engine's matrix; flag vector-only jobs from anyone else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner     <= '0;
            r_owner_vld <= 1'b0;
            r_err_stale <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_any && !w_win_nm && (!r_owner_vld || (r_owner != w_win_idx))) begin
                r_err_stale <= 1'b1;
            end else begin
                r_err_stale <= r_err_stale;
            end
            if ((r_state == DRAIN) && w_out_hs && w_last_rsp && r_job_nm) begin
                r_owner     <= r_gidx;
                r_owner_vld <= 1'b1;
            end else begin
                r_owner     <= r_owner;
                r_owner_vld <= r_owner_vld;
            end
        end
    end

    assign err_stale_matrix = r_err_stale;
`endif

endmodule

// File: tb/tb_matvec_job_arbiter.sv
// Scoreboard bench for matvec_job_arbiter: requester drivers, a behavioural engine, and a job-level monitor.
module tb_matvec_job_arbiter;
    localparam int N  = 2;
    localparam int W  = 14;
    localparam int OW = 28;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  req_valid, req_new_matrix, req_ready, rsp_valid, rsp_ready, grant;
    logic [N*W-1:0] req_data;
    logic [OW-1:0] rsp_data, mv_output_data;
    logic [W-1:0]  mv_input_data;
    logic          mv_input_valid, mv_input_ready, mv_new_matrix;
    logic          mv_output_valid, mv_output_ready, busy;
`ifdef MATVEC_ARB_OWNER_CHECK_EN
    logic          err_stale_matrix;
`endif

    matvec_job_arbiter #(.N_REQ(N), .WIDTH(W), .OUT_WIDTH(OW), .MAT_DIM(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_new_matrix(req_new_matrix),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mv_input_valid(mv_input_valid), .mv_input_ready(mv_input_ready), .mv_input_data(mv_input_data),
        .mv_new_matrix(mv_new_matrix), .mv_output_valid(mv_output_valid),
        .mv_output_ready(mv_output_ready), .mv_output_data(mv_output_data), .grant(grant),
`ifdef MATVEC_ARB_OWNER_CHECK_EN
        .err_stale_matrix(err_stale_matrix),
`endif
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mv_row(input int m[9], input int v[3], input int row);
        int acc = 0;
        for (int j = 0; j < 3; j++) acc += m[row*3 + j] * v[j];
        return acc;
    endfunction

    typedef struct { int req; logic [OW-1:0] data; } exp_t;
    exp_t sb[$];
    int   mdl_mat[9];

    // requester drivers
    int drv_jobs[N], drv_idx[N], drv_len[N], drv_nm_mode[N];
    int drv_gap_at[N], drv_gap_len[N], drv_gap_cnt[N], bp_cnt[N];
    bit drv_active[N], drv_nm[N], bp_arm[N];
    int drv_words[N][12];
    bit rnd_mode = 1'b0;
    bit seq_words = 1'b0;

    // behavioural engine
    int eng_cnt, eng_len;
    int eng_buf[12];
    int eng_mat[9];
    logic [OW-1:0] eng_q[$];
    int eng_in_total = 0;
    int stall_cnt = 0;

    // monitor model
    bit mon_en = 1'b0;
    int m_phase = 0, m_g = 0, m_ptr = 0, m_words = 0, m_len = 0, m_res = 0, m_pend_g = 0;
    bit m_nm = 1'b0, m_pend = 1'b0, m_pend_nm = 1'b0;
    bit m_err = 1'b0, m_own_vld = 1'b0;
    int m_own = 0;
    int mon_res_total = 0;
    int grant_log[$];

    task automatic start_job(input int r);
        drv_active[r] = 1'b1;
        drv_idx[r] = 0;
        drv_nm[r] = (drv_nm_mode[r] == 2) ? 1'($urandom_range(0, 1)) : 1'(drv_nm_mode[r]);
        drv_len[r] = drv_nm[r] ? 12 : 3;
        for (int i = 0; i < 12; i++)
            drv_words[r][i] = seq_words ? i + 1 : int'($urandom_range(0, 200)) - 100;
    endtask

    task automatic drive();
        int w;
        for (int r = 0; r < N; r++) begin
            w = drv_words[r][(drv_idx[r] < 12) ? drv_idx[r] : 0];
            req_valid[r] = drv_active[r] && (drv_gap_cnt[r] == 0) && !(rnd_mode && ($urandom_range(0, 4) == 0));
            req_new_matrix[r] = drv_nm[r];
            req_data[r*W +: W] = w[W-1:0];
            rsp_ready[r] = rnd_mode ? ($urandom_range(0, 3) != 0) : (bp_cnt[r] == 0);
        end
        mv_input_ready  = (eng_q.size() == 0) && (!rnd_mode || ($urandom_range(0, 3) != 0));
        mv_output_valid = (eng_q.size() != 0) && (!rnd_mode || ($urandom_range(0, 3) != 0));
        mv_output_data  = (eng_q.size() != 0) ? eng_q[0] : '0;
    endtask

    task automatic sample();
        int v[3];
        for (int r = 0; r < N; r++) begin
            if (drv_gap_cnt[r] > 0) drv_gap_cnt[r]--;
            if (bp_cnt[r] > 0) bp_cnt[r]--;
            if (req_valid[r] && req_ready[r]) begin
                if (drv_idx[r] == drv_gap_at[r]) drv_gap_cnt[r] = drv_gap_len[r];
                drv_idx[r]++;
                if (drv_idx[r] == drv_len[r]) begin
                    if (drv_nm[r]) for (int i = 0; i < 9; i++) mdl_mat[i] = drv_words[r][i];
                    for (int i = 0; i < 3; i++) v[i] = drv_words[r][(drv_nm[r] ? 9 : 0) + i];
                    for (int row = 0; row < 3; row++) sb.push_back('{r, OW'(mv_row(mdl_mat, v, row))});
                    drv_active[r] = 1'b0;
                    drv_jobs[r]--;
                    if (bp_arm[r]) begin bp_cnt[r] = 5; bp_arm[r] = 1'b0; end
                end
            end
            if (!drv_active[r] && drv_jobs[r] > 0) start_job(r);
        end
        if (mv_output_valid && !mv_output_ready) stall_cnt++;
        if (mv_output_valid && mv_output_ready) void'(eng_q.pop_front());
        if (mv_input_valid && mv_input_ready) begin
            if (eng_cnt == 0) eng_len = mv_new_matrix ? 12 : 3;
            eng_buf[eng_cnt] = int'($signed(mv_input_data));
            eng_cnt++;
            eng_in_total++;
            if (eng_cnt == eng_len) begin
                if (eng_len == 12) for (int i = 0; i < 9; i++) eng_mat[i] = eng_buf[i];
                for (int i = 0; i < 3; i++) v[i] = eng_buf[(eng_len == 12 ? 9 : 0) + i];
                for (int row = 0; row < 3; row++) eng_q.push_back(OW'(mv_row(eng_mat, v, row)));
                eng_cnt = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Monitor: protocol model per cycle plus result scoreboard.
    always @(negedge clk) begin
        bit was_idle;
        exp_t e;
        if (mon_en) begin
            if (m_pend) begin
                m_phase = 1; m_g = m_pend_g; m_nm = m_pend_nm;
                m_len = m_nm ? 12 : 3; m_words = 0; m_res = 0; m_pend = 1'b0;
                grant_log.push_back(m_g);
                if (!m_nm && (!m_own_vld || m_own != m_g)) m_err = 1'b1;
            end
            check("busy", 64'(busy), 64'(m_phase != 0));
            check("grant", 64'(grant), (m_phase != 0) ? 64'(1) << m_g : 64'(0));
            check("mv_new_matrix", 64'(mv_new_matrix), 64'(m_phase != 0 && m_nm));
            check("mv_input_valid", 64'(mv_input_valid), 64'(m_phase == 1 && req_valid[m_g]));
            check("req_ready", 64'(req_ready), (m_phase == 1 && mv_input_ready) ? 64'(1) << m_g : 64'(0));
            check("mv_output_ready", 64'(mv_output_ready), 64'(m_phase == 2 && rsp_ready[m_g]));
            check("rsp_valid", 64'(rsp_valid), (m_phase == 2 && mv_output_valid) ? 64'(1) << m_g : 64'(0));
            if (m_phase == 1 && req_valid[m_g])
                check("mv_input_data", 64'(mv_input_data), 64'(req_data[m_g*W +: W]));
`ifdef MATVEC_ARB_OWNER_CHECK_EN
            check("err_stale_matrix", 64'(err_stale_matrix), 64'(m_err));
`endif
            for (int r = 0; r < N; r++) begin
                if (rsp_valid[r] && rsp_ready[r]) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 64'(sb.size()), 64'(1));
                    end else begin
                        e = sb.pop_front();
                        check("rsp_owner", 64'(r), 64'(e.req));
                        check("rsp_data", 64'(rsp_data), 64'(e.data));
                    end
                    mon_res_total++;
                end
            end
            was_idle = (m_phase == 0);
            if (m_phase == 1 && mv_input_valid && mv_input_ready) begin
                m_words++;
                if (m_words == m_len) m_phase = 2;
            end else if (m_phase == 2 && mv_output_valid && mv_output_ready) begin
                m_res++;
                if (m_res == 3) begin
                    m_phase = 0;
                    m_ptr = (m_g + 1) % N;
                    if (m_nm) begin m_own = m_g; m_own_vld = 1'b1; end
                end
            end
            if (was_idle && (req_valid != '0)) begin
                m_pend = 1'b1;
                for (int k = N - 1; k >= 0; k--)
                    if (req_valid[(m_ptr + k) % N]) m_pend_g = (m_ptr + k) % N;
                m_pend_nm = req_new_matrix[m_pend_g];
            end
        end
    end

    task automatic do_reset(input int cycles);
        mon_en = 1'b0;
        reset = 1'b0;
        for (int r = 0; r < N; r++) begin
            drv_jobs[r] = 0; drv_active[r] = 1'b0; drv_idx[r] = 0; drv_len[r] = 3; drv_nm[r] = 1'b0;
            drv_gap_at[r] = -1; drv_gap_len[r] = 0; drv_gap_cnt[r] = 0; bp_cnt[r] = 0; bp_arm[r] = 1'b0;
            drv_nm_mode[r] = 2;
        end
        eng_cnt = 0; eng_len = 3; eng_q.delete(); sb.delete();
        for (int i = 0; i < 9; i++) begin eng_mat[i] = 0; mdl_mat[i] = 0; end
        drive();
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mv_in_valid", 64'(mv_input_valid), 64'(0));
        check("rst_mv_out_ready", 64'(mv_output_ready), 64'(0));
        check("rst_mv_new_matrix", 64'(mv_new_matrix), 64'(0));
        reset = 1'b1;
        m_phase = 0; m_ptr = 0; m_pend = 1'b0; m_err = 1'b0; m_own_vld = 1'b0;
        grant_log.delete();
        mon_en = 1'b1;
    endtask

    function automatic bit all_idle();
        for (int r = 0; r < N; r++) if (drv_active[r] || drv_jobs[r] > 0) return 1'b0;
        return (sb.size() == 0) && (m_phase == 0) && !m_pend && (eng_q.size() == 0);
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin cycle(); n++; end
        check({name, "_timeout"}, 64'(n < budget), 64'(1));
        repeat (2) cycle();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_in, base_res, n, jobs_total;
        reset = 1'b0;
        do_reset(2);

        // single requester, matrix job, words 1..12, no stalls
        seq_words = 1'b1; drv_nm_mode[0] = 1; drv_jobs[0] = 1;
        base_in = eng_in_total; base_res = mon_res_total;
        run_until_idle("t1", 300);
        check("t1_words", 64'(eng_in_total - base_in), 64'(12));
        check("t1_results", 64'(mon_res_total - base_res), 64'(3));
        check("t1_grants", 64'(grant_log.size()), 64'(1));
        seq_words = 1'b0;

        // contention from reset: 0, 1, 0
        do_reset(1);
        drv_jobs[0] = 2; drv_jobs[1] = 1;
        run_until_idle("t2", 500);
        check("t2_njobs", 64'(grant_log.size()), 64'(3));
        if (grant_log.size() == 3) begin
            check("t2_first", 64'(grant_log[0]), 64'(0));
            check("t2_second", 64'(grant_log[1]), 64'(1));
            check("t2_third", 64'(grant_log[2]), 64'(0));
        end

        // result backpressure: 5 stalled drain cycles
        drv_nm_mode[1] = 0; drv_jobs[1] = 1; bp_arm[1] = 1'b1;
        stall_cnt = 0; base_res = mon_res_total;
        run_until_idle("t3", 300);
        check("t3_stall_cycles", 64'(stall_cnt), 64'(5));
        check("t3_results", 64'(mon_res_total - base_res), 64'(3));

        // vector-only job with a 4-cycle input gap after the first word
        drv_nm_mode[0] = 0; drv_gap_at[0] = 0; drv_gap_len[0] = 4; drv_jobs[0] = 1;
        base_in = eng_in_total;
        run_until_idle("t4", 300);
        check("t4_words", 64'(eng_in_total - base_in), 64'(3));
        drv_gap_at[0] = -1;

        // randomized traffic
        rnd_mode = 1'b1; jobs_total = 0;
        for (int r = 0; r < N; r++) begin
            drv_nm_mode[r] = 2;
            drv_jobs[r] = int'($urandom_range(6, 10));
            jobs_total += drv_jobs[r];
        end
        base_res = mon_res_total;
        run_until_idle("t5", 8000);
        check("t5_results", 64'(mon_res_total - base_res), 64'(3 * jobs_total));
        rnd_mode = 1'b0;

        // reset in the middle of DRAIN
        drv_nm_mode[0] = 1; drv_jobs[0] = 1;
        run_until_idle("t6a", 300);
        drv_nm_mode[1] = 1; drv_jobs[1] = 1;
        base_res = mon_res_total; n = 0;
        while (mon_res_total == base_res && n < 300) begin cycle(); n++; end
        check("t6_first_result", 64'(mon_res_total - base_res), 64'(1));
        do_reset(1);
        drv_jobs[0] = 1; drv_jobs[1] = 1;
        run_until_idle("t6b", 500);
        check("t6_njobs", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() > 0) check("t6_first_after_reset", 64'(grant_log[0]), 64'(0));

`ifdef MATVEC_ARB_OWNER_CHECK_EN
        do_reset(1);
        drv_nm_mode[0] = 1; drv_jobs[0] = 1;
        run_until_idle("t7a", 300);
        check("t7_err_clean", 64'(err_stale_matrix), 64'(0));
        drv_nm_mode[1] = 0; drv_jobs[1] = 1;
        run_until_idle("t7b", 300);
        check("t7_err_set", 64'(err_stale_matrix), 64'(1));
`endif

        check("final_sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
